// File: rtl/instr_encoder.sv
// Packs ALU/branch/memory instruction fields into 16-bit words and streams them
// sequentially into instruction memory, one word every two cycles.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cls,
  input  logic [3:0]        op,
  input  logic              immed,
  input  logic [2:0]        reg_out,
  input  logic [2:0]        reg_a,
  input  logic [2:0]        reg_b,
  input  logic [4:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FULL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic [7:0]        errcnt_q, errcnt_nxt;
  logic [15:0]       word_q, word_nxt;
  logic              err_q, err_nxt;
  logic              done_q, done_nxt;

  logic              legal;
  logic              iform;
  logic [4:0]        opc;
  logic [15:0]       enc;

  // Field encoder: GT/LT/EQ (8..10) land on 14..16 via the same +6 offset as I-form ALU ops.
  always_comb begin
    legal = 1'b1;
    iform = 1'b0;
    opc   = '0;
    if (cls == 2'd0) begin
      if (op == 4'd0 || op > 4'd10) begin
        legal = 1'b0;
      end else if (op >= 4'd8) begin
        opc   = {1'b0, op} + 5'd6;
        legal = !immed;
      end else if (immed) begin
        opc   = {1'b0, op} + 5'd6;
        iform = 1'b1;
      end else begin
        opc   = {1'b0, op} - 5'd1;
      end
    end else begin
      opc   = {3'b100, cls};
      iform = 1'b1;
    end
    enc = iform ? {reg_out, reg_a, imm, opc} : {reg_out, reg_a, reg_b, 2'b00, opc};
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    count_nxt  = count_q;
    errcnt_nxt = errcnt_q;
    word_nxt   = word_q;
    err_nxt    = 1'b0;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE, FULL: begin
        if (start) begin
          state_nxt  = LOAD;
          addr_nxt   = '0;
          count_nxt  = '0;
          errcnt_nxt = '0;
        end
      end
      LOAD: begin
        if (start) begin
          addr_nxt   = '0;
          count_nxt  = '0;
          errcnt_nxt = '0;
        end else if (finish) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (in_valid) begin
          if (legal) begin
            word_nxt  = enc;
            state_nxt = WRITE;
          end else begin
            err_nxt = 1'b1;
            if (errcnt_q != 8'hFF) errcnt_nxt = errcnt_q + 8'd1;
          end
        end
      end
      WRITE: begin
        count_nxt = count_q + {{ADDR_W{1'b0}}, 1'b1};
        if (addr_q == '1) begin
          state_nxt = FULL;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      errcnt_q <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      count_q  <= count_nxt;
      errcnt_q <= errcnt_nxt;
      word_q   <= word_nxt;
      err_q    <= err_nxt;
      done_q   <= done_nxt;
    end
  end

  // Strobes decode straight from state so an async reset drops mem_we immediately.
  assign in_ready  = (state == LOAD);
  assign mem_we    = (state == WRITE);
  assign full      = (state == FULL);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign err_cnt   = errcnt_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule
